// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_pkg
//  Brief    : AHB-Lite encodings and initiator FSM state type.
//  Revision : 1.0
// ============================================================================
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_BURST     = 3'd2,
        ST_LAST_DATA = 3'd3,
        ST_ERR       = 3'd4
    } ahb_mst_state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_master_if
//  Brief    : AHB-Lite initiator turning one local command into a SINGLE or
//             INCR word burst. Optional AHB_MST_TIMEOUT_EN aborts long stalls.
//  Revision : 1.0
// ============================================================================
module ahb_master_if
    import ahb_pkg::*;
#(
    parameter int MAX_BEATS = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                         Hclk,
    input  logic                         Hresetn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [31:0]                  cmd_addr,
    input  logic [$clog2(MAX_BEATS)-1:0] cmd_len,
    input  logic [31:0]                  wr_data,
    output logic                         wr_pop,
    output logic [31:0]                  rd_data,
    output logic                         rd_valid,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   Htrans,
    output logic [31:0]                  Haddr,
    output logic                         Hwrite,
    output logic [2:0]                   Hsize,
    output logic [2:0]                   Hburst,
    output logic [31:0]                  Hwdata,
    input  logic                         Hready,
    input  logic [1:0]                   Hresp,
    input  logic [31:0]                  Hrdata
);

    localparam int c_len_w = $clog2(MAX_BEATS);

    ahb_mst_state_t       r_state;
    ahb_mst_state_t       w_state_nxt;
    logic [1:0]           w_htrans_nxt;
    logic [c_len_w-1:0]   r_cnt;
    logic                 r_live;
    logic                 w_load;
    logic                 w_step;
    logic                 w_pop;
    logic                 w_rd_beat;
    logic                 w_fin;
    logic                 w_fin_err;
    logic                 w_to_hit;

    assign cmd_ready = r_live && (r_state == ST_IDLE);
    assign wr_pop    = w_pop;
    assign Hsize     = HSIZE_WORD;

`ifdef AHB_MST_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT + 1);
    logic [c_to_w-1:0] r_to_cnt;

    assign w_to_hit = !Hready && (r_state != ST_IDLE) && (r_to_cnt == c_to_w'(TIMEOUT - 1));

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_to_cnt <= '0;
        end else if (Hready || (r_state == ST_IDLE) || w_to_hit) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + c_to_w'(1);
        end
    end
`else
    logic w_timeout_unused;
    assign w_timeout_unused = (TIMEOUT == 0);
    assign w_to_hit         = 1'b0;
`endif

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state <= ST_IDLE;
            Htrans  <= HTRANS_IDLE;
        end else begin
            r_state <= w_state_nxt;
            Htrans  <= w_htrans_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_htrans_nxt = Htrans;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_pop        = 1'b0;
        w_rd_beat    = 1'b0;
        w_fin        = 1'b0;
        w_fin_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    w_load       = 1'b1;
                    w_htrans_nxt = HTRANS_NONSEQ;
                    w_state_nxt  = ST_ADDR;
                end
            end
            ST_ADDR, ST_BURST, ST_LAST_DATA: begin
                // An error on a live data phase also cancels the pending SEQ address.
                if ((r_state != ST_ADDR) && (Hresp == HRESP_ERROR)) begin
                    w_htrans_nxt = HTRANS_IDLE;
                    if (Hready) begin
                        w_fin       = 1'b1;
                        w_fin_err   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ERR;
                    end
                end else if (Hready) begin
                    w_rd_beat = (r_state != ST_ADDR) && !Hwrite;
                    if (r_state == ST_LAST_DATA) begin
                        w_fin       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_pop = Hwrite;
                        if (r_cnt != '0) begin
                            w_step       = 1'b1;
                            w_htrans_nxt = HTRANS_SEQ;
                            w_state_nxt  = ST_BURST;
                        end else begin
                            w_htrans_nxt = HTRANS_IDLE;
                            w_state_nxt  = ST_LAST_DATA;
                        end
                    end
                end
            end
            ST_ERR: begin
                if (Hready) begin
                    w_fin       = 1'b1;
                    w_fin_err   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_htrans_nxt = HTRANS_IDLE;
                w_state_nxt  = ST_IDLE;
            end
        endcase
        if (w_to_hit) begin
            w_htrans_nxt = HTRANS_IDLE;
            w_state_nxt  = ST_IDLE;
            w_fin        = 1'b1;
            w_fin_err    = 1'b1;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Haddr    <= '0;
            Hwrite   <= 1'b0;
            Hburst   <= HBURST_SINGLE;
            Hwdata   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            r_cnt    <= '0;
            r_live   <= 1'b0;
        end else begin
            r_live   <= 1'b1;
            rd_valid <= w_rd_beat;
            done     <= w_fin;
            err      <= w_fin_err;
            if (w_rd_beat) begin
                rd_data <= Hrdata;
            end
            if (w_load) begin
                Haddr  <= cmd_addr;
                Hwrite <= cmd_write;
                Hburst <= (cmd_len == '0) ? HBURST_SINGLE : HBURST_INCR;
                r_cnt  <= cmd_len;
            end else if (w_step) begin
                Haddr <= Haddr + 32'd4;
                r_cnt <= r_cnt - c_len_w'(1);
            end
            // Write data is captured with its own address so it lands one cycle later.
            if (w_pop) begin
                Hwdata <= wr_data;
            end
        end
    end

    logic [8:0] w_kb_end;
    assign w_kb_end = {1'b0, cmd_addr[9:2]} + 9'(cmd_len);

    a_no_1kb_cross: assert property (@(posedge Hclk) disable iff (!Hresetn)
        (cmd_valid && cmd_ready) |-> !w_kb_end[8]);

    a_no_busy: assert property (@(posedge Hclk) disable iff (!Hresetn)
        Htrans != HTRANS_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_master_if
//  Brief    : Self-checking bench for ahb_master_if with an AHB slave model.
//  Revision : 1.0
// ============================================================================
module tb_ahb_master_if;
    import ahb_pkg::*;

    logic        Hclk = 1'b0;
    logic        Hresetn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic [31:0] wr_data = '0;
    logic        wr_pop, rd_valid, done, err, Hwrite;
    logic [31:0] rd_data, Haddr, Hwdata;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize, Hburst;
    logic        Hready = 1'b1;
    logic [1:0]  Hresp = 2'b00;
    logic [31:0] Hrdata = '0;

    always #5 Hclk = ~Hclk;

    ahb_master_if #(.MAX_BEATS(16), .TIMEOUT(4)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_pop(wr_pop),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .Htrans(Htrans), .Haddr(Haddr), .Hwrite(Hwrite), .Hsize(Hsize),
        .Hburst(Hburst), .Hwdata(Hwdata),
        .Hready(Hready), .Hresp(Hresp), .Hrdata(Hrdata)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] cfg_rd[16];
    logic [31:0] cfg_wr[16];
    int stall_beat, stall_n, err_beat, rand_stall;

    logic [31:0] obs_addr[$];
    logic [1:0]  obs_trans[$];
    logic [2:0]  obs_burst[$];
    logic        obs_write[$];
    logic [31:0] obs_wdata[$];
    logic [31:0] obs_rd[$];
    int          obs_pops, obs_stalls, obs_done_cyc, obs_hold_viol, obs_ready_viol;
    logic        obs_err;
    logic [1:0]  obs_trans_after_err;

    // Slave model: issues a command, answers each data phase from cfg_* and the
    // stall/error plan, and records what appeared on the bus.
    task automatic run_cmd(input logic wr, input logic [31:0] addr, input int len, input int budget);
        int c, wait_rdy, dp_beat, dp_k, dp_wait, pop_idx, err_c;
        logic dp_valid, acc, popped, prev_stall, p_write;
        logic [1:0] p_trans;
        logic [2:0] p_burst;
        logic [31:0] p_addr, p_wdata;
        obs_addr.delete(); obs_trans.delete(); obs_burst.delete(); obs_write.delete();
        obs_wdata.delete(); obs_rd.delete();
        obs_pops = 0; obs_stalls = 0; obs_done_cyc = -1; obs_hold_viol = 0; obs_ready_viol = 0;
        obs_err = 1'b0; obs_trans_after_err = 2'b11;
        cmd_write = wr; cmd_addr = addr; cmd_len = 4'(len); cmd_valid = 1'b1; wr_data = cfg_wr[0];
        wait_rdy = 0;
        while (!cmd_ready && wait_rdy < 20) begin
            @(posedge Hclk); #1;
            wait_rdy++;
        end
        @(posedge Hclk); #1;
        cmd_valid = 1'b0;
        dp_valid = 1'b0; dp_beat = 0; dp_k = 0; dp_wait = 0; pop_idx = 0; err_c = -10;
        prev_stall = 1'b0; p_trans = '0; p_addr = '0; p_wdata = '0; p_write = 1'b0; p_burst = '0;
        for (c = 1; c <= budget; c++) begin
            if (rd_valid) obs_rd.push_back(rd_data);
            if (done) begin
                obs_done_cyc = c;
                obs_err = err;
                break;
            end
            if (cmd_ready) obs_ready_viol++;
            if (prev_stall && (Htrans !== p_trans || Haddr !== p_addr || Hwdata !== p_wdata ||
                               Hwrite !== p_write || Hburst !== p_burst)) obs_hold_viol++;
            if (c == err_c + 1) obs_trans_after_err = Htrans;
            Hready = 1'b1; Hresp = HRESP_OKAY; Hrdata = $urandom;
            if (dp_valid) begin
                if (dp_beat == err_beat) begin
                    Hresp = HRESP_ERROR;
                    Hready = (dp_k != 0);
                    if (dp_k == 0) err_c = c;
                end else if (dp_k < dp_wait) begin
                    Hready = 1'b0;
                end else if (!wr) begin
                    Hrdata = cfg_rd[dp_beat];
                end
            end
            if (!Hready) obs_stalls++;
            wr_data = cfg_wr[pop_idx & 15];
            #1;
            popped = wr_pop;
            if (popped) obs_pops++;
            acc = Htrans[1] && Hready;
            prev_stall = !Hready && (Hresp == HRESP_OKAY);
            p_trans = Htrans; p_addr = Haddr; p_wdata = Hwdata; p_write = Hwrite; p_burst = Hburst;
            @(posedge Hclk); #1;
            if (popped) pop_idx++;
            if (dp_valid) begin
                if (Hready) begin
                    if (wr && Hresp == HRESP_OKAY) obs_wdata.push_back(p_wdata);
                    dp_valid = 1'b0;
                end else begin
                    dp_k++;
                end
            end
            if (acc) begin
                obs_addr.push_back(p_addr); obs_trans.push_back(p_trans);
                obs_burst.push_back(p_burst); obs_write.push_back(p_write);
                dp_valid = 1'b1;
                dp_beat = obs_addr.size() - 1;
                dp_k = 0;
                if (dp_beat == stall_beat) dp_wait = stall_n;
                else if (int'($urandom_range(0, 99)) < rand_stall) dp_wait = int'($urandom_range(1, 2));
                else dp_wait = 0;
            end
        end
        Hready = 1'b1; Hresp = HRESP_OKAY;
    endtask

    task automatic plan(input int sb, input int sn, input int eb, input int rs);
        stall_beat = sb; stall_n = sn; err_beat = eb; rand_stall = rs;
    endtask

    task automatic test_reset();
        #2;
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got=%b exp=0", cmd_ready); end
        n_vec++; if ({Htrans, Haddr, Hwrite, Hburst, Hwdata} !== '0) begin n_err++;
            $display("FAIL rst_bus got=%h/%h/%b/%h/%h exp=0", Htrans, Haddr, Hwrite, Hburst, Hwdata); end
        n_vec++; if ({rd_data, rd_valid, wr_pop, done, err} !== '0) begin n_err++;
            $display("FAIL rst_local got=%h/%b/%b/%b/%b exp=0", rd_data, rd_valid, wr_pop, done, err); end
        n_vec++; if (Hsize !== 3'b010) begin n_err++; $display("FAIL hsize got=%b exp=010", Hsize); end
        @(negedge Hclk); Hresetn = 1'b1;
        @(posedge Hclk); #1;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_single_write();
        cfg_wr[0] = 32'hDEAD_BEEF;
        plan(-1, 0, -1, 0);
        run_cmd(1'b1, 32'h8000_0000, 0, 20);
        n_vec++; if (obs_addr.size() != 1) begin n_err++; $display("FAIL sw_nbeats got=%0d exp=1", obs_addr.size()); end
        n_vec++; if (obs_addr[0] !== 32'h8000_0000 || obs_trans[0] !== HTRANS_NONSEQ || obs_write[0] !== 1'b1 ||
                     obs_burst[0] !== HBURST_SINGLE) begin n_err++;
            $display("FAIL sw_addr got=%h/%b/%b/%b exp=80000000/10/1/000", obs_addr[0], obs_trans[0], obs_write[0], obs_burst[0]); end
        n_vec++; if (obs_wdata.size() != 1 || obs_wdata[0] !== 32'hDEAD_BEEF) begin n_err++;
            $display("FAIL sw_wdata got=%h n=%0d exp=deadbeef", obs_wdata[0], obs_wdata.size()); end
        n_vec++; if (obs_pops != 1) begin n_err++; $display("FAIL sw_pops got=%0d exp=1", obs_pops); end
        n_vec++; if (obs_done_cyc != 3 || obs_err !== 1'b0) begin n_err++;
            $display("FAIL sw_done got=cyc%0d err%b exp=cyc3 err0", obs_done_cyc, obs_err); end
    endtask

    task automatic test_incr_read();
        for (int i = 0; i < 4; i++) cfg_rd[i] = 32'(17 * (i + 1));
        plan(-1, 0, -1, 0);
        run_cmd(1'b0, 32'h8400_0000, 3, 30);
        n_vec++; if (obs_addr.size() != 4) begin n_err++; $display("FAIL rd_nbeats got=%0d exp=4", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            n_vec++;
            if (obs_addr[i] !== 32'h8400_0000 + 32'(4 * i) || obs_trans[i] !== (i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ) ||
                obs_burst[i] !== HBURST_INCR) begin n_err++;
                $display("FAIL rd_addr%0d got=%h/%b/%b exp=%h", i, obs_addr[i], obs_trans[i], obs_burst[i], 32'h8400_0000 + 32'(4 * i)); end
        end
        n_vec++; if (obs_rd.size() != 4) begin n_err++; $display("FAIL rd_nvalid got=%0d exp=4", obs_rd.size()); end
        for (int i = 0; i < obs_rd.size() && i < 4; i++) begin
            n_vec++; if (obs_rd[i] !== cfg_rd[i]) begin n_err++; $display("FAIL rd_data%0d got=%h exp=%h", i, obs_rd[i], cfg_rd[i]); end
        end
        n_vec++; if (obs_done_cyc != 6 || obs_err !== 1'b0 || obs_pops != 0) begin n_err++;
            $display("FAIL rd_done got=cyc%0d err%b pops%0d exp=cyc6 err0 pops0", obs_done_cyc, obs_err, obs_pops); end
    endtask

    task automatic test_write_stall();
        for (int i = 0; i < 3; i++) cfg_wr[i] = $urandom;
        plan(1, 2, -1, 0);
        run_cmd(1'b1, 32'h8000_0100, 2, 30);
        n_vec++; if (obs_wdata.size() != 3) begin n_err++; $display("FAIL st_nw got=%0d exp=3", obs_wdata.size()); end
        for (int i = 0; i < obs_wdata.size() && i < 3; i++) begin
            n_vec++; if (obs_wdata[i] !== cfg_wr[i] || obs_addr[i] !== 32'h8000_0100 + 32'(4 * i)) begin n_err++;
                $display("FAIL st_beat%0d got=%h@%h exp=%h@%h", i, obs_wdata[i], obs_addr[i], cfg_wr[i], 32'h8000_0100 + 32'(4 * i)); end
        end
        n_vec++; if (obs_pops != 3) begin n_err++; $display("FAIL st_pops got=%0d exp=3", obs_pops); end
        n_vec++; if (obs_hold_viol != 0) begin n_err++; $display("FAIL st_hold got=%0d exp=0", obs_hold_viol); end
        n_vec++; if (obs_done_cyc != 7 || obs_err !== 1'b0) begin n_err++;
            $display("FAIL st_done got=cyc%0d err%b exp=cyc7 err0", obs_done_cyc, obs_err); end
    endtask

    task automatic test_read_error();
        for (int i = 0; i < 4; i++) cfg_rd[i] = $urandom;
        plan(-1, 0, 1, 0);
        run_cmd(1'b0, 32'h8800_0000, 3, 30);
        n_vec++; if (obs_addr.size() != 2) begin n_err++; $display("FAIL er_nbeats got=%0d exp=2", obs_addr.size()); end
        n_vec++; if (obs_trans_after_err !== HTRANS_IDLE) begin n_err++;
            $display("FAIL er_htrans got=%b exp=00", obs_trans_after_err); end
        n_vec++; if (obs_rd.size() != 1 || obs_rd[0] !== cfg_rd[0]) begin n_err++;
            $display("FAIL er_rd got=n%0d %h exp=n1 %h", obs_rd.size(), obs_rd[0], cfg_rd[0]); end
        n_vec++; if (obs_done_cyc != 5 || obs_err !== 1'b1) begin n_err++;
            $display("FAIL er_done got=cyc%0d err%b exp=cyc5 err1", obs_done_cyc, obs_err); end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 16; i++) cfg_rd[i] = 32'hA000_0000 | 32'(i + 1);
        plan(-1, 0, -1, 0);
        run_cmd(1'b0, 32'h8000_1000, 7, 3);
        #2 Hresetn = 1'b0;
        #1;
        n_vec++; if ({Htrans, Haddr, Hwrite, Hburst, Hwdata} !== '0) begin n_err++;
            $display("FAIL mr_bus got=%h/%h/%b/%h/%h exp=0", Htrans, Haddr, Hwrite, Hburst, Hwdata); end
        n_vec++; if ({rd_data, rd_valid, done, err, cmd_ready} !== '0) begin n_err++;
            $display("FAIL mr_local got=%h/%b/%b/%b/%b exp=0", rd_data, rd_valid, done, err, cmd_ready); end
        repeat (2) @(posedge Hclk);
        #1;
        n_vec++; if (done !== 1'b0 || cmd_ready !== 1'b0) begin n_err++;
            $display("FAIL mr_hold got=done%b rdy%b exp=0/0", done, cmd_ready); end
        @(negedge Hclk); Hresetn = 1'b1;
        @(posedge Hclk); #1;
        n_vec++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin n_err++;
            $display("FAIL mr_rel got=rdy%b done%b exp=1/0", cmd_ready, done); end
        cfg_wr[0] = $urandom;
        run_cmd(1'b1, 32'h8000_2000, 0, 20);
        n_vec++; if (obs_trans[0] !== HTRANS_NONSEQ || obs_done_cyc != 3 || obs_wdata[0] !== cfg_wr[0]) begin n_err++;
            $display("FAIL mr_restart got=%b cyc%0d %h exp=10 cyc3 %h", obs_trans[0], obs_done_cyc, obs_wdata[0], cfg_wr[0]); end
    endtask

    task automatic test_back_to_back();
        logic wr;
        int len, exp_done;
        logic [31:0] base;
        for (int k = 0; k < 25; k++) begin
            wr = 1'($urandom);
            len = int'($urandom_range(0, 15));
            base = {$urandom, 10'd0} | (32'($urandom_range(0, 255 - len)) << 2);
            for (int i = 0; i < 16; i++) begin cfg_wr[i] = $urandom; cfg_rd[i] = $urandom; end
            plan(-1, 0, -1, 30);
            run_cmd(wr, base, len, 200);
            n_vec++; if (obs_addr.size() != len + 1) begin n_err++;
                $display("FAIL rnd%0d_nbeats got=%0d exp=%0d", k, obs_addr.size(), len + 1); end
            for (int i = 0; i < obs_addr.size() && i <= len; i++) begin
                n_vec++;
                if (obs_addr[i] !== base + 32'(4 * i) || obs_trans[i] !== (i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ) ||
                    obs_write[i] !== wr || obs_burst[i] !== (len == 0 ? HBURST_SINGLE : HBURST_INCR)) begin n_err++;
                    $display("FAIL rnd%0d_addr%0d got=%h/%b/%b/%b exp=%h", k, i, obs_addr[i], obs_trans[i],
                             obs_write[i], obs_burst[i], base + 32'(4 * i)); end
                n_vec++;
                if (wr ? (obs_wdata[i] !== cfg_wr[i]) : (obs_rd[i] !== cfg_rd[i])) begin n_err++;
                    $display("FAIL rnd%0d_data%0d got=%h exp=%h", k, i, wr ? obs_wdata[i] : obs_rd[i], wr ? cfg_wr[i] : cfg_rd[i]); end
            end
            exp_done = len + 3 + obs_stalls;
            n_vec++; if (obs_done_cyc != exp_done || obs_err !== 1'b0) begin n_err++;
                $display("FAIL rnd%0d_done got=cyc%0d err%b exp=cyc%0d err0", k, obs_done_cyc, obs_err, exp_done); end
            n_vec++; if (obs_pops != (wr ? len + 1 : 0) || obs_hold_viol != 0 || obs_ready_viol != 0) begin n_err++;
                $display("FAIL rnd%0d_proto got=pops%0d hold%0d rdy%0d exp=%0d/0/0", k, obs_pops, obs_hold_viol,
                         obs_ready_viol, wr ? len + 1 : 0); end
        end
    endtask

    task automatic test_timeout();
        plan(0, 200, -1, 0);
`ifdef AHB_MST_TIMEOUT_EN
        run_cmd(1'b0, 32'h8C00_0000, 0, 40);
        n_vec++; if (obs_done_cyc != 6 || obs_err !== 1'b1) begin n_err++;
            $display("FAIL to_abort got=cyc%0d err%b exp=cyc6 err1", obs_done_cyc, obs_err); end
`else
        run_cmd(1'b0, 32'h8C00_0000, 0, 100);
        n_vec++; if (obs_done_cyc != -1 || cmd_ready !== 1'b0) begin n_err++;
            $display("FAIL to_wait got=cyc%0d rdy%b exp=no done, rdy0", obs_done_cyc, cmd_ready); end
`endif
        @(negedge Hclk); Hresetn = 1'b0;
        repeat (2) @(negedge Hclk);
        Hresetn = 1'b1;
        @(posedge Hclk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        plan(-1, 0, -1, 0);
        test_reset();
        test_single_write();
        test_incr_read();
        test_write_stall();
        test_read_error();
        test_reset_mid_burst();
        test_back_to_back();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
